bpu_ras: RTL and testbench

- Return-address stack stage directly downstream of the BTB in the BPU; consumes the BTB's next-PC/type prediction each fetch cycle.
- On CALL-type predictions, pushes the return address. On RET-type predictions, replaces the BTB target with the stack top.
- Emits the final registered prediction, plus a stack checkpoint, toward the PC generator and TAGE merge.
- Backend redirect restores the checkpoint and replays the resolved branch's stack effect.

---
 rtl/bpu_ras_pkg.sv | 31 +++
 rtl/bpu_ras_stack.sv | 109 ++++++++++
 rtl/bpu_ras.sv | 133 +++++++++++++
 tb/tb_bpu_ras.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_ras_pkg.sv
// bpu_ras_pkg: shared definitions for the return-address stack.
//   - Branch-type codes as produced by the BTB and by the backend.
//   - Instruction address width.
//   - Enable/disable constants.
//   - Return-address helper: the address of the slot after the call.
// Optional feature macro used by the importing files: RAS_CNT_EN.
package bpu_ras_pkg;

  localparam int unsigned InstAddrBus = 32;

  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  typedef enum logic [2:0] {
    TypeFORMAL   = 3'd0,
    TypeCOND     = 3'd1,
    TypeDIRECT   = 3'd2,
    TypeCALL     = 3'd3,
    TypeRET      = 3'd4,
    TypeINDIRECT = 3'd5
  } br_type_e;

  // The instruction sits at slot*4 inside a 32-byte fetch block. It returns to the next slot.
  function automatic logic [InstAddrBus-1:0] calc_ret_addr(
    input logic [InstAddrBus-1:0] pc,
    input logic [2:0]             slot
  );
    return {pc[InstAddrBus-1:5], slot, 2'b00} + 32'd4;
  endfunction

endpackage

// File: rtl/bpu_ras_stack.sv
// bpu_ras_stack: circular return-address storage with its pointer and valid-entry count.
// The requested operation is applied on top of a "base" state.
//   - When i_restore is set, the base is the checkpoint.
//   - Otherwise the base is the current state.
// o_top_* always shows the entry just below the base pointer, so the caller can decide the
// operation in the same cycle as a restore.
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_restore, i_restore_sp/cnt select the checkpoint as the base state
//   i_push, i_push_addr         write an entry at the base pointer and advance
//   i_pop                       retreat the pointer (the caller guarantees count > 0)
//   i_rc_inc, i_rc_dec          recursion counter update of the top entry (RAS_CNT_EN only)
//   o_sp, o_cnt                 current pointer and count
//   o_top_addr, o_top_rc        top entry relative to the base state
// Optional feature macro: RAS_CNT_EN (3-bit recursion counter per entry).
module bpu_ras_stack
  import bpu_ras_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3,
  parameter int unsigned CNT_W = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_restore,
  input  logic [PTR_W-1:0]       i_restore_sp,
  input  logic [CNT_W-1:0]       i_restore_cnt,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [InstAddrBus-1:0] i_push_addr,
`ifdef RAS_CNT_EN
  input  logic                   i_rc_inc,
  input  logic                   i_rc_dec,
  output logic [2:0]             o_top_rc,
`endif
  output logic [PTR_W-1:0]       o_sp,
  output logic [CNT_W-1:0]       o_cnt,
  output logic [InstAddrBus-1:0] o_top_addr
);

  logic [InstAddrBus-1:0] r_stack [DEPTH];
  logic [PTR_W-1:0]       r_sp;
  logic [CNT_W-1:0]       r_cnt;

  logic [PTR_W-1:0] w_base_sp;
  logic [CNT_W-1:0] w_base_cnt;
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_sp_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_base_sp  = i_restore ? i_restore_sp  : r_sp;
  assign w_base_cnt = i_restore ? i_restore_cnt : r_cnt;
  assign w_top_idx  = w_base_sp - PTR_W'(1);
  assign o_top_addr = r_stack[w_top_idx];
  assign o_sp       = r_sp;
  assign o_cnt      = r_cnt;

  always_comb begin
    w_sp_nxt  = w_base_sp;
    w_cnt_nxt = w_base_cnt;
    if (i_push) begin
      w_sp_nxt = w_base_sp + PTR_W'(1);
      // Count saturates; a push into a full stack silently overwrites the oldest entry.
      if (w_base_cnt != CNT_W'(DEPTH)) begin
        w_cnt_nxt = w_base_cnt + CNT_W'(1);
      end
    end else if (i_pop) begin
      w_sp_nxt  = w_base_sp - PTR_W'(1);
      w_cnt_nxt = w_base_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sp  <= '0;
      r_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_stack[i] <= '0;
      end
    end else begin
      r_sp  <= w_sp_nxt;
      r_cnt <= w_cnt_nxt;
      if (i_push) begin
        r_stack[w_base_sp] <= i_push_addr;
      end
    end
  end

`ifdef RAS_CNT_EN
  logic [2:0] r_rc [DEPTH];

  assign o_top_rc = r_rc[w_top_idx];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_rc[i] <= '0;
      end
    end else if (i_push) begin
      r_rc[w_base_sp] <= '0;
    end else if (i_rc_inc) begin
      r_rc[w_top_idx] <= r_rc[w_top_idx] + 3'd1;
    end else if (i_rc_dec) begin
      r_rc[w_top_idx] <= r_rc[w_top_idx] - 3'd1;
    end
  end
`endif

endmodule

// File: rtl/bpu_ras.sv
// bpu_ras: return-address stack stage placed after the BTB.
//   - On a CALL prediction it pushes the return address.
//   - On a RET prediction it replaces the BTB target with the stack top.
//   - It registers the final prediction together with a pre-update stack checkpoint.
//   - A backend redirect restores a checkpoint and replays the resolved branch.
//   - A redirect takes priority over a prediction in the same cycle; that prediction is dropped.
// Ports:
//   Clk, Rest                        clock, asynchronous active-low reset
//   PredAble/Pc/Slot/Type/Target     BTB prediction
//   RecoverAble/Sp/Cnt/Type/RetAddr  backend redirect with checkpoint
//   OutAble/Pc/Type                  registered final prediction
//   OutSp/OutCnt                     checkpoint (pointer and count before this prediction)
// Optional feature macro: RAS_CNT_EN (recursion counter folds repeated identical calls).
module bpu_ras
  import bpu_ras_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3,
  parameter int unsigned CNT_W = 4
) (
  input  logic                   Clk,
  input  logic                   Rest,
  input  logic                   PredAble,
  input  logic [InstAddrBus-1:0] PredPc,
  input  logic [2:0]             PredSlot,
  input  logic [2:0]             PredType,
  input  logic [InstAddrBus-1:0] PredTarget,
  input  logic                   RecoverAble,
  input  logic [PTR_W-1:0]       RecoverSp,
  input  logic [CNT_W-1:0]       RecoverCnt,
  input  logic [2:0]             RecoverType,
  input  logic [InstAddrBus-1:0] RecoverRetAddr,
  output logic                   OutAble,
  output logic [InstAddrBus-1:0] OutPc,
  output logic [2:0]             OutType,
  output logic [PTR_W-1:0]       OutSp,
  output logic [CNT_W-1:0]       OutCnt
);

  logic                   w_accept;
  logic                   w_active;
  logic [2:0]             w_type;
  logic [InstAddrBus-1:0] w_push_addr;
  logic [CNT_W-1:0]       w_base_cnt;
  logic                   w_nonempty;
  logic                   w_is_call;
  logic                   w_is_ret;
  logic                   w_push;
  logic                   w_pop;
  logic [PTR_W-1:0]       w_sp;
  logic [CNT_W-1:0]       w_cnt;
  logic [InstAddrBus-1:0] w_top_addr;

  logic                   r_out_able;
  logic [InstAddrBus-1:0] r_out_pc;
  logic [2:0]             r_out_type;
  logic [PTR_W-1:0]       r_out_sp;
  logic [CNT_W-1:0]       r_out_cnt;

  // A redirect wins; both paths share one decode of "the branch being applied this cycle".
  assign w_accept    = PredAble & ~RecoverAble;
  assign w_active    = PredAble | RecoverAble;
  assign w_type      = RecoverAble ? RecoverType : PredType;
  assign w_push_addr = RecoverAble ? RecoverRetAddr : calc_ret_addr(PredPc, PredSlot);
  assign w_base_cnt  = RecoverAble ? RecoverCnt : w_cnt;
  assign w_nonempty  = (w_base_cnt != '0);
  assign w_is_call   = w_active && (w_type == TypeCALL);
  assign w_is_ret    = w_active && (w_type == TypeRET) && w_nonempty;

`ifdef RAS_CNT_EN
  logic       w_rc_hit;
  logic       w_rc_ret;
  logic [2:0] w_top_rc;

  // A repeated call to the same return site folds into the top entry until its counter saturates.
  assign w_rc_hit = w_is_call && w_nonempty && (w_top_addr == w_push_addr) && (w_top_rc != 3'd7);
  assign w_rc_ret = w_is_ret && (w_top_rc != 3'd0);
  assign w_push   = w_is_call && !w_rc_hit;
  assign w_pop    = w_is_ret && !w_rc_ret;
`else
  assign w_push = w_is_call;
  assign w_pop  = w_is_ret;
`endif

  bpu_ras_stack #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_stack (
    .i_clk         (Clk),
    .i_rst_n       (Rest),
    .i_restore     (RecoverAble),
    .i_restore_sp  (RecoverSp),
    .i_restore_cnt (RecoverCnt),
    .i_push        (w_push),
    .i_pop         (w_pop),
    .i_push_addr   (w_push_addr),
`ifdef RAS_CNT_EN
    .i_rc_inc      (w_rc_hit),
    .i_rc_dec      (w_rc_ret),
    .o_top_rc      (w_top_rc),
`endif
    .o_sp          (w_sp),
    .o_cnt         (w_cnt),
    .o_top_addr    (w_top_addr)
  );

  // The payload only loads on an accepted prediction; consumers qualify it with OutAble.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_out_able <= Disable;
      r_out_pc   <= '0;
      r_out_type <= '0;
      r_out_sp   <= '0;
      r_out_cnt  <= '0;
    end else begin
      r_out_able <= w_accept ? Enable : Disable;
      if (w_accept) begin
        r_out_pc   <= w_is_ret ? w_top_addr : PredTarget;
        r_out_type <= PredType;
        r_out_sp   <= w_sp;
        r_out_cnt  <= w_cnt;
      end
    end
  end

  assign OutAble = r_out_able;
  assign OutPc   = r_out_pc;
  assign OutType = r_out_type;
  assign OutSp   = r_out_sp;
  assign OutCnt  = r_out_cnt;

endmodule

// File: tb/tb_bpu_ras.sv
// tb_bpu_ras: directed checks plus randomized traffic against an array/arithmetic model of the
// return-address stack. Honours RAS_CNT_EN when defined.
module tb_bpu_ras;
  import bpu_ras_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam int CNT_W = 4;
`ifdef RAS_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Rest = 1'b0;
  logic              PredAble = 1'b0;
  logic [31:0]       PredPc = '0;
  logic [2:0]        PredSlot = '0;
  logic [2:0]        PredType = '0;
  logic [31:0]       PredTarget = '0;
  logic              RecoverAble = 1'b0;
  logic [PTR_W-1:0]  RecoverSp = '0;
  logic [CNT_W-1:0]  RecoverCnt = '0;
  logic [2:0]        RecoverType = '0;
  logic [31:0]       RecoverRetAddr = '0;
  logic              OutAble;
  logic [31:0]       OutPc;
  logic [2:0]        OutType;
  logic [PTR_W-1:0]  OutSp;
  logic [CNT_W-1:0]  OutCnt;

  bpu_ras #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) dut (
    .Clk            (Clk),
    .Rest           (Rest),
    .PredAble       (PredAble),
    .PredPc         (PredPc),
    .PredSlot       (PredSlot),
    .PredType       (PredType),
    .PredTarget     (PredTarget),
    .RecoverAble    (RecoverAble),
    .RecoverSp      (RecoverSp),
    .RecoverCnt     (RecoverCnt),
    .RecoverType    (RecoverType),
    .RecoverRetAddr (RecoverRetAddr),
    .OutAble        (OutAble),
    .OutPc          (OutPc),
    .OutType        (OutType),
    .OutSp          (OutSp),
    .OutCnt         (OutCnt)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  int          m_rc  [DEPTH];
  int          m_sp = 0;
  int          m_cnt = 0;
  logic        exp_able = 1'b0;
  logic [31:0] exp_pc = '0;
  logic [2:0]  exp_type = '0;
  int          exp_sp = 0;
  int          exp_cnt = 0;

  function automatic logic [31:0] ret_of(input logic [31:0] pc, input logic [2:0] slot);
    return (pc & 32'hFFFF_FFE0) + 32'(slot) * 32'd4 + 32'd4;
  endfunction

  task automatic m_apply(input int t, input logic [31:0] ra);
    int top;
    top = (m_sp + DEPTH - 1) % DEPTH;
    if (t == 3) begin
      if (CntEn && m_cnt > 0 && m_mem[top] == ra && m_rc[top] < 7) begin
        m_rc[top]++;
      end else begin
        m_mem[m_sp] = ra;
        m_rc[m_sp]  = 0;
        m_sp  = (m_sp + 1) % DEPTH;
        m_cnt = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
      end
    end else if (t == 4 && m_cnt > 0) begin
      if (CntEn && m_rc[top] > 0) begin
        m_rc[top]--;
      end else begin
        m_sp  = top;
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge Clk or negedge Rest);
      if (!Rest) begin
        for (int i = 0; i < DEPTH; i++) begin
          m_mem[i] = '0;
          m_rc[i]  = 0;
        end
        m_sp = 0; m_cnt = 0;
        exp_able = 1'b0; exp_pc = '0; exp_type = '0; exp_sp = 0; exp_cnt = 0;
      end else if (RecoverAble) begin
        exp_able = 1'b0;
        m_sp  = int'(RecoverSp);
        m_cnt = int'(RecoverCnt);
        m_apply(int'(RecoverType), RecoverRetAddr);
      end else if (PredAble) begin
        exp_able = 1'b1;
        exp_type = PredType;
        exp_sp   = m_sp;
        exp_cnt  = m_cnt;
        exp_pc   = PredTarget;
        if (PredType == 3'd4 && m_cnt > 0) exp_pc = m_mem[(m_sp + DEPTH - 1) % DEPTH];
        m_apply(int'(PredType), ret_of(PredPc, PredSlot));
      end else begin
        exp_able = 1'b0;
      end
    end
  end

  // Compare process: outputs are registered, so mid-cycle sampling is stable.
  initial begin
    forever begin
      @(negedge Clk);
      if (Rest) begin
        check("model_able", 32'(OutAble), 32'(exp_able));
        if (exp_able) begin
          check("model_pc", OutPc, exp_pc);
          check("model_type", 32'(OutType), 32'(exp_type));
          check("model_sp", 32'(OutSp), exp_sp);
          check("model_cnt", 32'(OutCnt), exp_cnt);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pred(input logic [2:0] t, input logic [31:0] pc, input logic [2:0] slot,
                      input logic [31:0] tgt);
    PredAble = 1'b1; PredType = t; PredPc = pc; PredSlot = slot; PredTarget = tgt;
    RecoverAble = 1'b0;
    @(negedge Clk);
    PredAble = 1'b0;
  endtask

  task automatic reset_pulse();
    #2 Rest = 1'b0;
    #1;
    check("async_rst_able", 32'(OutAble), 32'd0);
    check("async_rst_pc", OutPc, 32'd0);
    check("async_rst_type", 32'(OutType), 32'd0);
    check("async_rst_sp", 32'(OutSp), 32'd0);
    check("async_rst_cnt", 32'(OutCnt), 32'd0);
    @(negedge Clk);
    Rest = 1'b1;
  endtask

  logic [31:0] ra_prev;
  int          r;

  initial begin
    repeat (2) @(negedge Clk);
    check("rst_able", 32'(OutAble), 32'd0);
    check("rst_pc", OutPc, 32'd0);
    Rest = 1'b1;
    @(negedge Clk);

    // Empty stack: RET falls back to the BTB target.
    pred(3'd4, 32'h5000, 3'd0, 32'h1000);
    check("empty_ret_pc", OutPc, 32'h1000);
    check("empty_ret_cnt", 32'(OutCnt), 32'd0);
    check("empty_ret_able", 32'(OutAble), 32'd1);

    // CALL then RET.
    pred(3'd3, 32'h2000, 3'd3, 32'h7777);
    check("call_pc", OutPc, 32'h7777);
    check("call_type", 32'(OutType), 32'd3);
    pred(3'd4, 32'h0, 3'd0, 32'hDEAD0000);
    check("ret_pc", OutPc, 32'h2010);
    check("ret_sp", 32'(OutSp), 32'd1);
    pred(3'd0, 32'h0, 3'd0, 32'h40);
    check("after_ret_sp", 32'(OutSp), 32'd0);

    // Overflow: nine distinct calls, only the newest eight survive.
    for (int k = 1; k <= 9; k++) pred(3'd3, 32'(k * 32'h100 - 32'h20), 3'd7, 32'hC000);
    for (int k = 9; k >= 2; k--) begin
      pred(3'd4, 32'h0, 3'd0, 32'hBEEF);
      check("ovf_ret_pc", OutPc, 32'(k * 32'h100));
    end
    pred(3'd4, 32'h0, 3'd0, 32'hBEEF0000);
    check("ovf_empty_pc", OutPc, 32'hBEEF0000);
    check("ovf_empty_cnt", 32'(OutCnt), 32'd0);

    // Recover beats a concurrent prediction and replays a CALL at the checkpoint.
    reset_pulse();
    pred(3'd3, 32'h100, 3'd0, 32'h0);
    pred(3'd3, 32'h200, 3'd0, 32'h0);
    pred(3'd3, 32'h300, 3'd0, 32'h0);
    PredAble = 1'b1; PredType = 3'd3; PredPc = 32'h900; PredSlot = 3'd0; PredTarget = 32'h1;
    RecoverAble = 1'b1; RecoverSp = 3'd1; RecoverCnt = 4'd1; RecoverType = 3'd3;
    RecoverRetAddr = 32'h4444;
    @(negedge Clk);
    PredAble = 1'b0; RecoverAble = 1'b0;
    check("recover_able", 32'(OutAble), 32'd0);
    pred(3'd4, 32'h0, 3'd0, 32'hAAAA);
    check("recover_ret_pc", OutPc, 32'h4444);
    check("recover_ret_sp", 32'(OutSp), 32'd2);
    check("recover_ret_cnt", 32'(OutCnt), 32'd2);
    pred(3'd4, 32'h0, 3'd0, 32'hAAAA);
    check("recover_ret2_pc", OutPc, 32'h104);

    // Back-to-back alternating CALL/RET.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] pc;
      logic [2:0]  sl;
      pc = $urandom; sl = 3'($urandom_range(0, 7));
      ra_prev = ret_of(pc, sl);
      pred(3'd3, pc, sl, 32'h0);
      check("b2b_call_able", 32'(OutAble), 32'd1);
      pred(3'd4, 32'h0, 3'd0, 32'h0);
      check("b2b_ret_able", 32'(OutAble), 32'd1);
      check("b2b_ret_pc", OutPc, ra_prev);
    end

    // Identical calls: folded with the recursion counter, stacked without it.
    reset_pulse();
    repeat (3) pred(3'd3, 32'h3000, 3'd0, 32'h0);
    pred(3'd0, 32'h0, 3'd0, 32'h0);
    check("rec_cnt", 32'(OutCnt), CntEn ? 32'd1 : 32'd3);
    for (int i = 0; i < 3; i++) begin
      pred(3'd4, 32'h0, 3'd0, 32'h0);
      check("rec_ret_pc", OutPc, 32'h3004);
    end
    pred(3'd0, 32'h0, 3'd0, 32'h0);
    check("rec_cnt_after", 32'(OutCnt), 32'd0);

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      PredAble = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      PredType = (r < 4) ? 3'd3 : (r < 8) ? 3'd4 : 3'($urandom_range(0, 5));
      PredPc = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) << 5 : $urandom;
      PredSlot = 3'($urandom_range(0, 1));
      PredTarget = $urandom;
      RecoverAble = ($urandom_range(0, 11) == 0);
      RecoverSp = 3'($urandom_range(0, 7));
      RecoverCnt = 4'($urandom_range(0, DEPTH));
      RecoverType = 3'($urandom_range(0, 5));
      RecoverRetAddr = 32'($urandom_range(0, 3)) * 32'h20 + 32'd4;
      if (c == 1500) begin
        PredAble = 1'b0; RecoverAble = 1'b0;
        reset_pulse();
      end else begin
        @(negedge Clk);
      end
    end
    PredAble = 1'b0; RecoverAble = 1'b0;
    repeat (2) @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
